// File: rtl/stream_pkg.sv
// Shared types and helpers for the four-lane word collector.
package stream_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_t;

    // Lane k of a packed group occupies bits [lane_lsb(k, width) +: width].
    function automatic int lane_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register; a load in the drain cycle replaces the entry.
module stream_out_reg #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_reg;
    logic          valid_next;
    logic [DW-1:0] data_reg;

    always_comb begin
        valid_next = valid_reg;
        if (load) begin
            valid_next = 1'b1;
        end else if (valid_reg && ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            // Data only moves on a load, so it stays put while the sink stalls.
            if (load) begin
                data_reg <= load_data;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/stream_collect4.sv
// Regroups a serialized word stream into 4-word vectors, lane 0 in the LSBs.
module stream_collect4
    import stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_first,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_err,
    output logic                   err_misalign,
    output logic [CNT_W-1:0]       group_cnt
);

    lane_t                   lane_reg;
    lane_t                   lane_next;
    logic                    accept;
    logic                    misalign;
    logic                    load;
    logic [LANES*WIDTH-1:0]  group_data;
    logic                    err_reg;
    logic [CNT_W-1:0]        cnt_reg;

    // Lane 3 may only complete a group if the output slot is free this cycle.
    assign in_ready = !(lane_reg == LANE3 && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign misalign = accept && in_first && (lane_reg != LANE0);
    assign load     = accept && !misalign && (lane_reg == LANE3);

    always_comb begin
        lane_next = lane_reg;
        if (misalign) begin
            lane_next = LANE1;
        end else if (accept) begin
            case (lane_reg)
                LANE0:   lane_next = LANE1;
                LANE1:   lane_next = LANE2;
                LANE2:   lane_next = LANE3;
                LANE3:   lane_next = LANE0;
                default: lane_next = LANE0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg <= LANE0;
        end else begin
            lane_reg <= lane_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : gen_slot
            localparam lane_t SLOT_LANE = lane_t'(gi);
            logic [WIDTH-1:0] slot_reg;
            logic             slot_we;

            // A misaligned first word restarts the group in slot 0.
            assign slot_we = misalign ? (gi == 0)
                                      : (accept && lane_reg == SLOT_LANE);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (slot_we) begin
                    slot_reg <= in_data;
                end
            end

            assign group_data[lane_lsb(gi, WIDTH) +: WIDTH] = slot_reg;
        end
    endgenerate

    assign group_data[lane_lsb(LANES - 1, WIDTH) +: WIDTH] = in_data;

    stream_out_reg #(
        .DW(LANES * WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (group_data),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (misalign) begin
            err_reg <= 1'b1;
        end else if (clr_err) begin
            err_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (out_valid && out_ready) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign err_misalign = err_reg;
    assign group_cnt    = cnt_reg;

endmodule

// File: tb/tb_stream_collect4.sv
// Randomized scoreboard bench for stream_collect4 with a word-queue reference model.
module tb_stream_collect4;

    localparam int W  = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_first;
    logic            in_ready;
    logic [4*W-1:0]  out_data;
    logic            out_valid;
    logic            out_ready;
    logic            clr_err;
    logic            err_misalign;
    logic [CW-1:0]   group_cnt;

    always #5 clk = ~clk;

    stream_collect4 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .clr_err      (clr_err),
        .err_misalign (err_misalign),
        .group_cnt    (group_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [4*W-1:0] exp_q[$];
    logic [W-1:0]   partial[$];
    bit             err_exp;
    int             groups_exp;
    int             hs_count;
    bit             rand_ready;
    bit             prev_hold;
    logic [4*W-1:0] held_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Reference: collect accepted words, a first word restarts a pending group.
    function automatic void model_word(input logic [W-1:0] w, input bit first);
        if (first && partial.size() != 0) begin
            partial.delete();
            err_exp = 1'b1;
        end
        partial.push_back(w);
        if (partial.size() == 4) begin
            exp_q.push_back({partial[3], partial[2], partial[1], partial[0]});
            partial.delete();
            groups_exp++;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && out_valid)
                chk("hold_stable", out_data, held_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_group", out_data, 64'hx);
                end else begin
                    chk("group", out_data, exp_q.pop_front());
                end
                hs_count++;
            end
            prev_hold = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic step(output bit acc);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (clr_err) err_exp = 1'b0;
        if (acc) model_word(in_data, in_first);
        #1;
    endtask

    task automatic drive_word(input logic [W-1:0] w, input bit first, input bit clr);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        in_first = first;
        clr_err  = clr;
        for (int i = 0; i < 200 && !done; i++) begin
            step(acc);
            done = acc;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", w);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic wait_drain();
        bit acc;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
            else step(acc);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_group_cnt", 64'(group_cnt), 64'd0);
        chk("rst_err", 64'(err_misalign), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        partial.delete();
        err_exp    = 1'b0;
        groups_exp = 0;
        hs_count   = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        out_ready  = 1'b1;
        clr_err    = 1'b0;
        rand_ready = 1'b0;
        err_exp    = 1'b0;
        groups_exp = 0;
        hs_count   = 0;
        prev_hold  = 1'b0;
        #1;
        do_reset();

        // Continuous words 1..8 with sink always ready.
        for (int i = 1; i <= 8; i++) begin
            drive_word(W'(i), (i % 4) == 1, 1'b0);
            if (i == 4) begin
                chk("t1_valid_at_beat4", 64'(out_valid), 64'd1);
                chk("t1_group0", out_data, 64'h0004_0003_0002_0001);
            end
        end
        chk("t1_valid_at_beat8", 64'(out_valid), 64'd1);
        chk("t1_group1", out_data, 64'h0008_0007_0006_0005);
        idle(2);
        chk("t1_group_cnt", 64'(group_cnt), 64'd2);

        // Backpressure: second group stalls at lane 3 while the first is held.
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) drive_word(W'(16 + i), (i % 4) == 1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0018;
        for (int i = 0; i < 3; i++) begin
            bit acc;
            step(acc);
            chk("t2_in_ready_low", 64'(in_ready), 64'd0);
            chk("t2_held_group", out_data, 64'h0014_0013_0012_0011);
        end
        out_ready = 1'b1;
        drive_word(16'h0018, 1'b0, 1'b0);
        chk("t2_replace_valid", 64'(out_valid), 64'd1);
        chk("t2_second_group", out_data, 64'h0018_0017_0016_0015);
        wait_drain();
        chk("t2_group_cnt", 64'(group_cnt), 64'd4);

        // Misaligned first word restarts the group.
        drive_word(16'h0021, 1'b1, 1'b0);
        drive_word(16'h0022, 1'b0, 1'b0);
        drive_word(16'h00AA, 1'b1, 1'b0);
        chk("t3_err_set", 64'(err_misalign), 64'd1);
        drive_word(16'h0023, 1'b0, 1'b0);
        drive_word(16'h0024, 1'b0, 1'b0);
        drive_word(16'h0025, 1'b0, 1'b0);
        chk("t3_realigned_group", out_data, 64'h0025_0024_0023_00AA);
        chk("t3_err_sticky", 64'(err_misalign), 64'd1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t3_err_cleared", 64'(err_misalign), 64'd0);

        // Set wins over a simultaneous clear.
        drive_word(16'h0031, 1'b1, 1'b0);
        drive_word(16'h0032, 1'b1, 1'b1);
        chk("t4_set_over_clr", 64'(err_misalign), 64'd1);
        for (int i = 3; i <= 5; i++) drive_word(W'(16'h0030 + i), 1'b0, 1'b0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t4_err_model", 64'(err_misalign), 64'(err_exp));
        wait_drain();

        // Random gaps and random sink readiness, 1000 words.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            drive_word(W'($urandom), partial.size() == 0, 1'b0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain();
        chk("t5_groups_emitted", 64'(hs_count), 64'd250);
        chk("t5_model_groups", 64'(groups_exp), 64'd250);
        chk("t5_group_cnt_wrapped", 64'(group_cnt), 64'(250 % 16));
        chk("t5_err_clean", 64'(err_misalign), 64'd0);

        // Reset while a group is held and a partial group is pending.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) drive_word(W'(16'h0040 + i), (i % 4) == 1, 1'b0);
        chk("t6_valid_before_rst", 64'(out_valid), 64'd1);
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) drive_word(W'(16'h0050 + i), 1'b0, 1'b0);
        chk("t6_fresh_group", out_data, 64'h0054_0053_0052_0051);
        wait_drain();

        // Counter wrap: 16 groups return to 0, the 17th gives 1.
        do_reset();
        for (int g = 0; g < 16; g++)
            for (int i = 0; i < 4; i++) drive_word(W'($urandom), i == 0, 1'b0);
        wait_drain();
        chk("t7_cnt_after_16", 64'(group_cnt), 64'd0);
        for (int i = 0; i < 4; i++) drive_word(W'($urandom), i == 0, 1'b0);
        wait_drain();
        chk("t7_cnt_after_17", 64'(group_cnt), 64'd1);
        chk("t7_handshakes", 64'(hs_count), 64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_collect4.md
# stream_collect4

Downstream companion to the 4:1 RAM streaming mux. It consumes the serialized word stream, one WIDTH-bit word per accepted beat. It regroups every four consecutive words into one 4×WIDTH vector, lane 0 in the LSBs, and hands it to the matrix-multiply datapath over a valid/ready handshake. The block provides group alignment via a start-of-group flag, a sticky misalignment error and a group counter for debug.

## Interface
- WIDTH, 16, bits per word
- CNT_W, 16, width of the group counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  serialized word
- in_valid  in  1  in_data valid
- in_first  in  1  with in_valid: this word is lane 0 of a new group
- in_ready  out  1  word accepted when in_valid && in_ready
- out_data  out  4*WIDTH  packed group; lane k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  out_data holds a complete group
- out_ready  in  1  group consumed when out_valid && out_ready
- clr_err  in  1  synchronous clear of err_misalign
- err_misalign  out  1  sticky; in_first seen while a partial group was pending
- group_cnt  out  CNT_W  groups emitted (output handshakes), wraps modulo 2^CNT_W

## Operation
- The lane counter `lane` (0..3) is the only state machine. States are LANE0, LANE1, LANE2 and LANE3. Each accepted beat advances the counter by one; from LANE3 it returns to LANE0.
- Accepted beats in LANE0..LANE2 write the assembly register slot `lane`.
- An accepted beat in LANE3 loads out_data with {in_data, slot2, slot1, slot0} and sets out_valid.
- An accepted beat with in_first while lane≠0:
  - The partial group is discarded.
  - The word is written as slot 0 and lane becomes 1.
  - err_misalign is set.
- in_first while lane=0 is normal.
- When lane=0, in_first is ignored for the error logic.
- Backpressure: in_ready = !(lane==3 && out_valid && !out_ready).
  - Lanes 0..2 always accept.
  - Lane 3 accepts when the output register is empty or is being drained in the same cycle.
- Output register:
  - out_valid clears on an output handshake unless it is reloaded in the same cycle.
  - out_data is stable while out_valid && !out_ready.
- group_cnt increments on every output handshake and wraps from all-ones to 0.
- err_misalign:
  - Set has priority over clr_err in the same cycle.
  - Cleared only by clr_err or reset.
- Words with in_valid low are ignored. The lane counter holds.

## Timing
- Reset (async assert, sync-safe deassert) sets the following: lane=0, assembly slots=0, out_data=0, out_valid=0, err_misalign=0, group_cnt=0.
- in_ready is combinational from lane/out_valid/out_ready. With rst_n low, in_ready reads 1 but no state changes.
- Latency: the LANE3 beat is accepted at edge N, and out_valid is high from edge N.
- Throughput: one word per cycle sustained while the sink accepts at least one group per 4 cycles. There are no bubbles between groups.
- Simultaneous output handshake and LANE3 acceptance in the same cycle: the new group replaces the old one and out_valid stays 1. group_cnt increments once, for the drained group.
- A reset mid-group discards all partial data. The first beat after reset is lane 0 regardless of in_first.

## Structure
- Package `stream_pkg`: localparam LANES=4; typedef lane_t (2-bit); the packing function for lane k at [k*WIDTH +: WIDTH].
- One natural sub-module: `stream_out_reg`, a single-entry valid/ready holding register with load/drain and a same-cycle reload.
- The lane FSM, the assembly slots, the error and the counter stay in the top module.

## Test plan
- Reset, then continuous words 0x0001..0x0008 with out_ready=1 → two groups, 0x0004_0003_0002_0001 and then 0x0008_0007_0006_0005. out_valid is high at the edge of the 4th and the 8th beat. group_cnt=2.
- out_ready=0 after the first group; feed 8 words → in_ready drops at lane 3 of the second group and the first group holds stable. Raise out_ready → both groups are emitted in order and no word is lost.
- After 2 words, send in_first with 0x00AA then 3 more words → err_misalign=1 and the group is 0x....._00AA in lane 0. Assert clr_err → err_misalign=0 on the next cycle.
- Assert in_first and clr_err on the same misaligned beat → err_misalign=1.
- Random in_valid gaps and random out_ready, 1000 words → the output equals the reference packing of the input and group_cnt=250.
- Assert rst_n low mid-group and while out_valid=1 → all outputs return to reset values immediately, asynchronously. The next 4 words form a fresh group.
- Preload group_cnt to its wrap condition by emitting 2^CNT_W groups with CNT_W=4 → the 17th handshake gives group_cnt=1 after the wrap from 15 to 0.
